// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer: debounced two-button entry of operand a, operand b and opcode for the ALU result stage.
// Define ALU_SEQ_LIVE_PREVIEW_EN to let the operand being entered follow sw live.
module alu_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] sw,
    input  logic       btn_load,
    input  logic       btn_clear,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [3:0] select,
    output logic       valid,
    output logic [1:0] phase,
    output logic       op_err
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_OP, SHOW} state_t;

    logic [1:0] btn, press;
    assign btn = {btn_clear, btn_load};

    for (genvar i = 0; i < 2; i++) begin : g_db
        logic s0, s1, deb;
        logic [CW-1:0] cnt;
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                s0  <= 1'b0;
                s1  <= 1'b0;
                deb <= 1'b0;
                cnt <= '0;
            end else begin
                s0 <= btn[i];
                s1 <= s0;
                if (s1 == deb)
                    cnt <= '0;
                else if (cnt == CMAX) begin
                    cnt <= '0;
                    deb <= s1;
                end else
                    cnt <= cnt + 1'b1;
            end
        // press fires on the same edge the debounced level rises, so it lasts one cycle
        assign press[i] = s1 && !deb && cnt == CMAX;
    end

    state_t state, state_n;
    logic [7:0] a_reg, b_reg, a_n, b_n;
    logic [3:0] op_reg, op_n;
    logic       err_reg, err_n, bad_op;

    assign bad_op = sw[3:0] == 4'hD || sw[3:0] == 4'hE;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state   <= LOAD_A;
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            err_reg <= 1'b0;
        end else begin
            state   <= state_n;
            a_reg   <= a_n;
            b_reg   <= b_n;
            op_reg  <= op_n;
            err_reg <= err_n;
        end

    always_comb begin
        state_n = state;
        a_n     = a_reg;
        b_n     = b_reg;
        op_n    = op_reg;
        err_n   = err_reg;
        if (press[1]) begin
            state_n = LOAD_A;
            a_n     = '0;
            b_n     = '0;
            op_n    = '0;
            err_n   = 1'b0;
        end else if (press[0]) begin
            case (state)
                LOAD_A: begin
                    a_n     = sw;
                    state_n = LOAD_B;
                end
                LOAD_B: begin
                    b_n     = sw;
                    state_n = LOAD_OP;
                end
                LOAD_OP: begin
                    op_n    = bad_op ? 4'h0 : sw[3:0];
                    err_n   = bad_op;
                    state_n = SHOW;
                end
                default: state_n = LOAD_A;
            endcase
        end
    end

`ifdef ALU_SEQ_LIVE_PREVIEW_EN
    assign a      = state == LOAD_A ? sw : a_reg;
    assign b      = state == LOAD_B ? sw : b_reg;
    assign select = state == LOAD_A ? 4'h1 : state == LOAD_B ? 4'h2 : state == SHOW ? op_reg : 4'h0;
`else
    assign a      = a_reg;
    assign b      = b_reg;
    assign select = state == SHOW ? op_reg : 4'h0;
`endif
    assign valid  = state == SHOW;
    assign phase  = state;
    assign op_err = err_reg;
endmodule

// File: tb/tb_alu_input_sequencer.sv
// tb_alu_input_sequencer: timestamped scoreboard bench for alu_input_sequencer with DEBOUNCE_CYCLES=4.
module tb_alu_input_sequencer;
    localparam int D = 4;

    logic       clk = 1'b0, reset_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       btn_load = 1'b0, btn_clear = 1'b0;
    logic [7:0] a, b;
    logic [3:0] select;
    logic       valid, op_err;
    logic [1:0] phase;

    alu_input_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset_n(reset_n), .sw(sw), .btn_load(btn_load), .btn_clear(btn_clear),
        .a(a), .b(b), .select(select), .valid(valid), .phase(phase), .op_err(op_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [7:0] a, b;
        logic [3:0] sel;
        logic       v;
        logic [1:0] ph;
        logic       err;
    } exp_t;

    exp_t q[$];
    exp_t e_mon, e_dir;
    int n_checks = 0, n_fail = 0;

    int         m_ph = 0;
    logic [7:0] m_a = 0, m_b = 0;
    logic [3:0] m_op = 0;
    logic       m_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, got, want);
        end
    endtask

    function automatic exp_t expect_now(input int due);
        exp_t e;
        e.due = due;
        e.ph  = m_ph[1:0];
        e.v   = m_ph == 3;
        e.err = m_err;
`ifdef ALU_SEQ_LIVE_PREVIEW_EN
        e.a   = m_ph == 0 ? sw : m_a;
        e.b   = m_ph == 1 ? sw : m_b;
        e.sel = m_ph == 0 ? 4'h1 : m_ph == 1 ? 4'h2 : m_ph == 3 ? m_op : 4'h0;
`else
        e.a   = m_a;
        e.b   = m_b;
        e.sel = m_ph == 3 ? m_op : 4'h0;
`endif
        return e;
    endfunction

    function automatic logic [23:0] vis();
`ifdef ALU_SEQ_LIVE_PREVIEW_EN
        return {20'b0, valid, phase, op_err};
`else
        return {a, b, select, valid, phase, op_err};
`endif
    endfunction

    task automatic model_clear();
        m_ph = 0; m_a = 0; m_b = 0; m_op = 0; m_err = 0;
    endtask

    task automatic model_load(input logic [7:0] s);
        case (m_ph)
            0: begin m_a = s; m_ph = 1; end
            1: begin m_b = s; m_ph = 2; end
            2: begin
                m_err = s[3:0] == 4'd13 || s[3:0] == 4'd14;
                m_op  = m_err ? 4'h0 : s[3:0];
                m_ph  = 3;
            end
            default: m_ph = 0;
        endcase
    endtask

    // Monitor: at a scheduled update compare against the model, otherwise outputs must hold still.
    logic [23:0] last = '0;
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            e_mon = q.pop_front();
            chk("sb_a", a, e_mon.a);
            chk("sb_b", b, e_mon.b);
            chk("sb_select", select, e_mon.sel);
            chk("sb_valid", valid, e_mon.v);
            chk("sb_phase", phase, e_mon.ph);
            chk("sb_op_err", op_err, e_mon.err);
        end else if (q.size() > 0 && q[0].due < cyc) begin
            chk("sb_missed_slot", q[0].due, cyc);
            void'(q.pop_front());
        end else
            chk("no_spurious_change", vis(), last);
        last = vis();
    end

    task automatic press(input bit ld, input bit cl, input logic [7:0] s, input int hold);
        @(posedge clk);
        #2;
        sw = s;
        btn_load = ld;
        btn_clear = cl;
        if (cl) model_clear();
        else model_load(s);
        q.push_back(expect_now(cyc + D + 2));
        repeat (hold) @(posedge clk);
        #2;
        btn_load = 0;
        btn_clear = 0;
        repeat (2 * D) @(posedge clk);
    endtask

    task automatic check_dir(input string nm);
        e_dir = expect_now(0);
        chk({nm, "_a"}, a, e_dir.a);
        chk({nm, "_b"}, b, e_dir.b);
        chk({nm, "_select"}, select, e_dir.sel);
        chk({nm, "_valid"}, valid, e_dir.v);
        chk({nm, "_phase"}, phase, e_dir.ph);
        chk({nm, "_op_err"}, op_err, e_dir.err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d pending", q.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rs;
        int r;
        repeat (3) @(posedge clk);
        #2;
        check_dir("reset_hold");
        reset_n = 1;
        repeat (2) @(posedge clk);
        #2;
        check_dir("reset");

        // bounce: 2-cycle highs never reach the 4-cycle debounce count
        for (int i = 0; i < 5; i++) begin
            btn_load = 1;
            repeat (2) @(posedge clk);
            #2;
            btn_load = 0;
            repeat (2) @(posedge clk);
            #2;
        end
        repeat (10) @(posedge clk);
        #2;
        chk("bounce_phase", phase, 2'd0);
        chk("bounce_a", a, 8'h00);

        press(1, 0, 8'h3C, 6);
        press(1, 0, 8'h05, 6);
        press(1, 0, 8'h0C, 6);
        chk("full_a", a, 8'h3C);
        chk("full_b", b, 8'h05);
        chk("full_select", select, 4'hC);
        chk("full_valid", valid, 1'b1);
        chk("full_phase", phase, 2'd3);

        press(1, 0, 8'h00, 6);
        press(1, 0, 8'h11, 100);
        chk("held_phase", phase, 2'd1);

        press(1, 0, 8'h22, 6);
        press(1, 0, 8'hFD, 6);
        chk("badop_select", select, 4'h0);
        chk("badop_err", op_err, 1'b1);
        chk("badop_valid", valid, 1'b1);
        press(1, 0, 8'h00, 6);
        press(1, 0, 8'h10, 6);
        press(1, 0, 8'h20, 6);
        press(1, 0, 8'h03, 6);
        chk("goodop_err", op_err, 1'b0);
        chk("goodop_select", select, 4'h3);

        press(1, 0, 8'h00, 6);
        press(1, 0, 8'h77, 6);
        press(1, 1, 8'h99, 6);
        chk("collide_phase", phase, 2'd0);
        chk("collide_a", a, 8'h00);
        chk("collide_b", b, 8'h00);

        press(1, 0, 8'h44, 6);
        press(1, 0, 8'h55, 6);
        chk("pre_reset_phase", phase, 2'd2);
        @(posedge clk);
        #2;
        sw = 8'h00;
        reset_n = 0;
        model_clear();
        q.push_back(expect_now(cyc));
        #1;
        check_dir("async_reset");
        @(posedge clk);
        #2;
        reset_n = 1;
        repeat (3) @(posedge clk);

`ifdef ALU_SEQ_LIVE_PREVIEW_EN
        #2;
        sw = 8'hA5;
        #1;
        chk("preview_a", a, 8'hA5);
        chk("preview_select", select, 4'h1);
        repeat (2) @(posedge clk);
`endif

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            rs = 8'($urandom);
            if (r < 85) press(1, 0, rs, $urandom_range(6, 12));
            else if (r < 95) press(0, 1, rs, $urandom_range(6, 12));
            else press(1, 1, rs, $urandom_range(6, 12));
        end

        repeat (10) @(posedge clk);
        #2;
        check_dir("final");
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
